rf_writeback: RTL and testbench



---
 rtl/rf_writeback.sv | 214 +++++++++++++++++++++
 tb/tb_rf_writeback.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// Register-file write-side driver: ALU/load arbitration, load alignment and busy scoreboard.
// Optional WB_PERF_EN adds per-source write counters and an ALU-blocks-hold cycle counter.

module rf_writeback_chk (
  input logic clk,
  input logic rst_n,
  input logic rsp_orphan
);

  // Memory must never return data for a load that was not issued.
  property p_no_orphan_rsp;
    @(posedge clk) disable iff (!rst_n) !rsp_orphan;
  endproperty

  a_no_orphan_rsp: assert property (p_no_orphan_rsp)
    else $error("rf_writeback: memory response with empty load queue");

endmodule

module rf_writeback #(
  parameter int LQ_DEPTH = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  output logic            ld_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_rready,
  output logic [31:0]     busy_mask,
  output logic            WrEn_RF,
  output logic [4:0]      WAddr_RF,
  output logic [XLEN-1:0] WD_RF
`ifdef WB_PERF_EN
  ,
  output logic [31:0]     perf_alu_wr,
  output logic [31:0]     perf_ld_wr,
  output logic [31:0]     perf_alu_block
`endif
);

  localparam int PW = $clog2(LQ_DEPTH);

  function automatic logic [XLEN-1:0] extract_load(
    input logic [2:0]      f3,
    input logic [1:0]      off,
    input logic [XLEN-1:0] word
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  logic [4:0]      lq_rd_r  [LQ_DEPTH];
  logic [2:0]      lq_f3_r  [LQ_DEPTH];
  logic [1:0]      lq_off_r [LQ_DEPTH];
  logic [PW:0]     wr_ptr_r;
  logic [PW:0]     rd_ptr_r;
  logic [PW-1:0]   wr_idx_s;
  logic [PW-1:0]   rd_idx_s;
  logic            lq_full_s;
  logic            lq_empty_s;
  logic            push_s;
  logic            pop_s;
  logic            orphan_s;
  logic            hold_valid_r;
  logic [4:0]      hold_rd_r;
  logic [XLEN-1:0] hold_data_r;
  logic            drain_s;
  logic [XLEN-1:0] head_data_s;
  logic [31:0]     busy_r;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;

  assign wr_idx_s   = wr_ptr_r[PW-1:0];
  assign rd_idx_s   = rd_ptr_r[PW-1:0];
  assign lq_empty_s = (wr_ptr_r == rd_ptr_r);
  assign lq_full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_idx_s == rd_idx_s);

  // busy_r[0] is never set, so loads to x0 never stall on the scoreboard.
  assign ld_ready   = !lq_full_s && !busy_r[ld_rd];
  assign drain_s    = hold_valid_r && !alu_valid;
  assign mem_rready = !hold_valid_r || drain_s;
  assign push_s     = ld_issue && ld_ready;
  assign pop_s      = mem_rvalid && mem_rready && !lq_empty_s;
  assign orphan_s   = mem_rvalid && mem_rready && lq_empty_s;
  assign busy_mask  = busy_r;
  assign head_data_s = extract_load(lq_f3_r[rd_idx_s], lq_off_r[rd_idx_s], mem_rdata);

  // Scoreboard set/clear masks for this cycle.
  always_comb begin
    set_mask_s = 32'h0000_0000;
    clr_mask_s = 32'h0000_0000;
    if (push_s && (ld_rd != 5'd0)) begin
      set_mask_s[ld_rd] = 1'b1;
    end else begin
      set_mask_s = 32'h0000_0000;
    end
    if (drain_s && (hold_rd_r != 5'd0)) begin
      clr_mask_s[hold_rd_r] = 1'b1;
    end else begin
      clr_mask_s = 32'h0000_0000;
    end
  end

  // Load queue storage; entries need no reset since pointers gate their use.
  always_ff @(posedge clk) begin
    if (push_s) begin
      lq_rd_r[wr_idx_s]  <= ld_rd;
      lq_f3_r[wr_idx_s]  <= ld_funct3;
      lq_off_r[wr_idx_s] <= ld_off;
    end
  end

  // Queue pointers, hold register and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      hold_valid_r <= 1'b0;
      hold_rd_r    <= 5'd0;
      hold_data_r  <= {XLEN{1'b0}};
      busy_r       <= 32'h0000_0000;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r     <= rd_ptr_r + (PW+1)'(1);
        hold_valid_r <= 1'b1;
        hold_rd_r    <= lq_rd_r[rd_idx_s];
        hold_data_r  <= head_data_s;
      end else if (drain_s) begin
        hold_valid_r <= 1'b0;
      end
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // Registered write port; ALU wins, hold register drains when the ALU is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WrEn_RF  <= 1'b0;
      WAddr_RF <= 5'd0;
      WD_RF    <= {XLEN{1'b0}};
    end else if (alu_valid) begin
      WrEn_RF <= (alu_rd != 5'd0);
      if (alu_rd != 5'd0) begin
        WAddr_RF <= alu_rd;
        WD_RF    <= alu_data;
      end
    end else if (drain_s) begin
      WrEn_RF <= (hold_rd_r != 5'd0);
      if (hold_rd_r != 5'd0) begin
        WAddr_RF <= hold_rd_r;
        WD_RF    <= hold_data_r;
      end
    end else begin
      WrEn_RF <= 1'b0;
    end
  end

`ifdef WB_PERF_EN
  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_alu_wr    <= 32'd0;
      perf_ld_wr     <= 32'd0;
      perf_alu_block <= 32'd0;
    end else begin
      if (alu_valid && (alu_rd != 5'd0)) begin
        perf_alu_wr <= perf_alu_wr + 32'd1;
      end
      if (drain_s && (hold_rd_r != 5'd0)) begin
        perf_ld_wr <= perf_ld_wr + 32'd1;
      end
      if (hold_valid_r && alu_valid) begin
        perf_alu_block <= perf_alu_block + 32'd1;
      end
    end
  end
`endif

  rf_writeback_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsp_orphan (orphan_s)
  );

endmodule

// File: tb/tb_rf_writeback.sv
// Directed self-checking bench for rf_writeback (default build).

module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic        ld_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic [31:0] busy_mask;
  logic        WrEn_RF;
  logic [4:0]  WAddr_RF;
  logic [31:0] WD_RF;

  int total = 0;
  int bad   = 0;

  rf_writeback #(.LQ_DEPTH(4), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_issue   (ld_issue),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_off     (ld_off),
    .ld_ready   (ld_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rready (mem_rready),
    .busy_mask  (busy_mask),
    .WrEn_RF    (WrEn_RF),
    .WAddr_RF   (WAddr_RF),
    .WD_RF      (WD_RF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_rt(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] rdata, input logic [31:0] exp, input string tag);
    logic [31:0] m;
    m = 32'h0;
    m[rd] = 1'b1;
    ld_issue = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_off = off;
    #1 chk({tag, "_ready"}, {31'd0, ld_ready}, 32'd1);
    tick();
    ld_issue = 1'b0;
    chk({tag, "_busy_set"}, busy_mask, m);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    #1 chk({tag, "_rready"}, {31'd0, mem_rready}, 32'd1);
    tick();
    mem_rvalid = 1'b0;
    chk({tag, "_busy_hold"}, busy_mask, m);
    chk({tag, "_no_early_wr"}, {31'd0, WrEn_RF}, 32'd0);
    tick();
    chk({tag, "_wren"}, {31'd0, WrEn_RF}, 32'd1);
    chk({tag, "_waddr"}, {27'd0, WAddr_RF}, {27'd0, rd});
    chk({tag, "_wd"}, WD_RF, exp);
    chk({tag, "_busy_clr"}, busy_mask, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    ld_issue = 1'b0; ld_rd = 5'd0; ld_funct3 = 3'b000; ld_off = 2'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) tick();
    chk("rst_wren", {31'd0, WrEn_RF}, 32'd0);
    chk("rst_waddr", {27'd0, WAddr_RF}, 32'd0);
    chk("rst_wd", WD_RF, 32'h0);
    chk("rst_busy", busy_mask, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_mem_rready", {31'd0, mem_rready}, 32'd1);

    // ALU write, then rd=0 variant
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    tick();
    chk("alu_wren", {31'd0, WrEn_RF}, 32'd1);
    chk("alu_waddr", {27'd0, WAddr_RF}, 32'd5);
    chk("alu_wd", WD_RF, 32'hDEAD_BEEF);
    alu_rd = 5'd0; alu_data = 32'h1234_5678;
    tick();
    chk("alu_x0_wren", {31'd0, WrEn_RF}, 32'd0);
    alu_valid = 1'b0;
    tick();

    // load extraction
    load_rt(5'd7, 3'b000, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80, "lb");
    load_rt(5'd7, 3'b100, 2'd3, 32'h80FF_1234, 32'h0000_0080, "lbu");
    load_rt(5'd8, 3'b001, 2'd2, 32'h80FF_1234, 32'hFFFF_80FF, "lh");
    load_rt(5'd8, 3'b101, 2'd0, 32'h80FF_1234, 32'h0000_1234, "lhu");
    load_rt(5'd6, 3'b010, 2'd1, 32'h80FF_1234, 32'h80FF_1234, "lw");
    load_rt(5'd6, 3'b000, 2'd1, 32'h80FF_1234, 32'h0000_0012, "lb_off1");
    load_rt(5'd6, 3'b000, 2'd2, 32'h80FF_1234, 32'hFFFF_FFFF, "lb_off2");
    load_rt(5'd6, 3'b011, 2'd0, 32'h80FF_1234, 32'h0000_0000, "bad_f3");

    // fill queue, then drain in order
    for (int i = 1; i <= 4; i++) begin
      ld_issue = 1'b1; ld_rd = 5'(i); ld_funct3 = 3'b010; ld_off = 2'd0;
      tick();
    end
    ld_issue = 1'b0; ld_rd = 5'd5;
    #1 chk("lq_full", {31'd0, ld_ready}, 32'd0);
    chk("lq_busy4", busy_mask, 32'h0000_001E);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    chk("lq_ready_after_pop", {31'd0, ld_ready}, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      mem_rdata = 32'(i) * 32'h1111_1111;
      #1 chk("lq_rready", {31'd0, mem_rready}, 32'd1);
      tick();
      d = 32'(i - 1) * 32'h1111_1111;
      chk("lq_order_addr", {27'd0, WAddr_RF}, 32'(i - 1));
      chk("lq_order_wd", WD_RF, d);
      chk("lq_order_wren", {31'd0, WrEn_RF}, 32'd1);
    end
    mem_rvalid = 1'b0;
    tick();
    chk("lq_last_addr", {27'd0, WAddr_RF}, 32'd4);
    chk("lq_last_wd", WD_RF, 32'h4444_4444);
    chk("lq_busy_clr", busy_mask, 32'h0);

    // ALU conflicts with a load response
    ld_issue = 1'b1; ld_rd = 5'd10; ld_funct3 = 3'b010; ld_off = 2'd0;
    tick();
    ld_issue = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h0000_0001;
    tick();
    mem_rvalid = 1'b0;
    chk("cf_alu1_addr", {27'd0, WAddr_RF}, 32'd11);
    chk("cf_alu1_wd", WD_RF, 32'h0000_0001);
    #1 chk("cf_rready_blk1", {31'd0, mem_rready}, 32'd0);
    alu_rd = 5'd12; alu_data = 32'h0000_0002;
    tick();
    chk("cf_alu2_addr", {27'd0, WAddr_RF}, 32'd12);
    chk("cf_busy_hold", busy_mask, 32'h0000_0400);
    #1 chk("cf_rready_blk2", {31'd0, mem_rready}, 32'd0);
    alu_rd = 5'd13; alu_data = 32'h0000_0003;
    tick();
    chk("cf_alu3_addr", {27'd0, WAddr_RF}, 32'd13);
    alu_valid = 1'b0;
    #1 chk("cf_rready_drain", {31'd0, mem_rready}, 32'd1);
    tick();
    chk("cf_ld_wren", {31'd0, WrEn_RF}, 32'd1);
    chk("cf_ld_addr", {27'd0, WAddr_RF}, 32'd10);
    chk("cf_ld_wd", WD_RF, 32'hA5A5_A5A5);
    chk("cf_busy_clr", busy_mask, 32'h0);
    tick();
    chk("cf_idle_wren", {31'd0, WrEn_RF}, 32'd0);

    // same-rd stall
    ld_issue = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b010; ld_off = 2'd0;
    tick();
    ld_funct3 = 3'b000;
    #1 chk("raw_stall", {31'd0, ld_ready}, 32'd0);
    tick();
    ld_issue = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("raw_first_addr", {27'd0, WAddr_RF}, 32'd9);
    chk("raw_first_wd", WD_RF, 32'h0000_0099);
    chk("raw_busy_clr", busy_mask, 32'h0);
    load_rt(5'd9, 3'b010, 2'd0, 32'h0909_0987, 32'h0909_0987, "raw_second");

    // reset with loads outstanding
    ld_issue = 1'b1; ld_rd = 5'd20; ld_funct3 = 3'b010;
    tick();
    ld_rd = 5'd21;
    tick();
    ld_issue = 1'b0; ld_rd = 5'd20;
    chk("mr_busy", busy_mask, 32'h0030_0000);
    rst_n = 1'b0;
    #1;
    chk("mr_busy_clr", busy_mask, 32'h0);
    chk("mr_wren", {31'd0, WrEn_RF}, 32'd0);
    chk("mr_ld_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_wr", {31'd0, WrEn_RF}, 32'd0);
    end
    load_rt(5'd22, 3'b010, 2'd0, 32'h2222_0000, 32'h2222_0000, "mr_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
